// File: rtl/addsub_pkg.sv
// Shared definitions for the adder/subtractor result stage: default width,
// skid-buffer occupancy encoding and the packed entry stored per result.
package addsub_pkg;

  localparam int ADDSUB_WIDTH = 4;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } occ_state_t;

  typedef struct packed {
    logic [ADDSUB_WIDTH-1:0] result;
    logic                    carry;
    logic                    borrow;
    logic                    zero;
    logic                    neg;
    logic                    ovf;
  } entry_t;

endpackage

// File: rtl/addsub_flag_gen.sv
// Combinational status-flag derivation for one adder/subtractor result.
// Optional macro ADDSUB_SAT_EN clamps overflowed results to the signed
// max/min; zero and neg then describe the clamped value.
module addsub_flag_gen
  import addsub_pkg::*;
#(
  parameter int WIDTH = ADDSUB_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mode,
  input  logic [WIDTH-1:0] s,
  input  logic             cout,
  output entry_t           entry
);

  localparam int MSB = WIDTH - 1;

  logic             ovf;
  logic [WIDTH-1:0] result;

  // Derive overflow, the emitted result and the flags that follow from it
  always_comb begin
    if (mode) begin
      ovf = (a[MSB] != b[MSB]) && (s[MSB] != a[MSB]);
    end else begin
      ovf = (a[MSB] == b[MSB]) && (s[MSB] != a[MSB]);
    end
`ifdef ADDSUB_SAT_EN
    if (ovf) begin
      result = a[MSB] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end else begin
      result = s;
    end
`else
    result = s;
`endif
    entry.result = result;
    entry.carry  = ~mode & cout;
    entry.borrow = mode & ~cout;
    entry.zero   = (result == '0);
    entry.neg    = result[MSB];
    entry.ovf    = ovf;
  end

endmodule

// File: rtl/addsub_result_stage.sv
// Registered result stage behind the 4-bit adder/subtractor: a 2-entry skid
// buffer with valid/ready on both sides plus a saturating overflow counter.
// Optional macro ADDSUB_SAT_EN enables result clamping in addsub_flag_gen.
module addsub_result_stage
  import addsub_pkg::*;
#(
  parameter int WIDTH = ADDSUB_WIDTH,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_mode,
  input  logic [WIDTH-1:0] in_s,
  input  logic             in_cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_carry,
  output logic             out_borrow,
  output logic             out_zero,
  output logic             out_neg,
  output logic             out_ovf,
  input  logic             ovf_clr,
  output logic [CNT_W-1:0] ovf_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  occ_state_t state;
  entry_t     new_entry;
  entry_t     head;
  entry_t     tail;
  logic       push;
  logic       pop;

  addsub_flag_gen #(
    .WIDTH(WIDTH)
  ) u_flag_gen (
    .a    (in_a),
    .b    (in_b),
    .mode (in_mode),
    .s    (in_s),
    .cout (in_cout),
    .entry(new_entry)
  );

  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready;

  // Occupancy FSM moving entries through head/tail with registered handshakes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= EMPTY;
      head      <= '0;
      tail      <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      case (state)
        EMPTY: begin
          if (push) begin
            head      <= new_entry;
            state     <= ONE;
            out_valid <= 1'b1;
          end
        end
        ONE: begin
          if (push && !pop) begin
            tail     <= new_entry;
            state    <= FULL;
            in_ready <= 1'b0;
          end else if (pop && !push) begin
            state     <= EMPTY;
            out_valid <= 1'b0;
          end else if (push && pop) begin
            head <= new_entry;
          end
        end
        FULL: begin
          if (pop) begin
            head     <= tail;
            state    <= ONE;
            in_ready <= 1'b1;
          end
        end
        default: begin
          state     <= EMPTY;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

  // Saturating count of accepted overflow results; clear wins over increment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_cnt <= '0;
    end else if (ovf_clr) begin
      ovf_cnt <= '0;
    end else if (push && new_entry.ovf && (ovf_cnt != CNT_MAX)) begin
      ovf_cnt <= ovf_cnt + 1'b1;
    end
  end

  assign out_result = head.result;
  assign out_carry  = head.carry;
  assign out_borrow = head.borrow;
  assign out_zero   = head.zero;
  assign out_neg    = head.neg;
  assign out_ovf    = head.ovf;

endmodule

// File: tb/tb_addsub_result_stage.sv
// Self-checking bench for addsub_result_stage: directed scenarios plus
// randomized traffic against an arithmetic reference model and a FIFO
// scoreboard. Build with ADDSUB_SAT_EN defined to exercise clamping.
module tb_addsub_result_stage;

  typedef struct {
    logic [3:0] res;
    logic       c;
    logic       b;
    logic       z;
    logic       n;
    logic       o;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_a;
  logic [3:0] in_b;
  logic       in_mode;
  logic [3:0] in_s;
  logic       in_cout;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_result;
  logic       out_carry;
  logic       out_borrow;
  logic       out_zero;
  logic       out_neg;
  logic       out_ovf;
  logic       ovf_clr;
  logic [7:0] ovf_cnt;

  int   totalCount;
  int   badCount;
  int   modelCnt;
  exp_t expQ[$];

  addsub_result_stage #(
    .WIDTH(4),
    .CNT_W(8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_mode   (in_mode),
    .in_s      (in_s),
    .in_cout   (in_cout),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_result(out_result),
    .out_carry (out_carry),
    .out_borrow(out_borrow),
    .out_zero  (out_zero),
    .out_neg   (out_neg),
    .out_ovf   (out_ovf),
    .ovf_clr   (ovf_clr),
    .ovf_cnt   (ovf_cnt)
  );

  // Free-running 10-unit clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Count one comparison and report it when observed differs from expected
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    totalCount++;
    if (observed !== expected) begin
      badCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Expected stage entry derived from integer arithmetic on the operands
  function automatic exp_t computeExpected(input logic [3:0] a, input logic [3:0] b, input logic m);
    exp_t e;
    int   ua;
    int   ub;
    int   sa;
    int   sb;
    int   ures;
    int   sres;
    logic [3:0] raw;
    ua = int'(a);
    ub = int'(b);
    sa = a[3] ? ua - 16 : ua;
    sb = b[3] ? ub - 16 : ub;
    ures = m ? ua - ub : ua + ub;
    sres = m ? sa - sb : sa + sb;
    raw = 4'((ures + 32) % 16);
    e.c = !m && (ures > 15);
    e.b = m && (ua < ub);
    e.o = (sres > 7) || (sres < -8);
`ifdef ADDSUB_SAT_EN
    if (sres > 7) e.res = 4'd7;
    else if (sres < -8) e.res = 4'd8;
    else e.res = raw;
`else
    e.res = raw;
`endif
    e.z = (e.res == 4'd0);
    e.n = e.res[3];
    return e;
  endfunction

  // Compare all DUT outputs with the scoreboard's current view
  task automatic checkCycle();
    checkOutput("out_valid", 32'(out_valid), 32'(expQ.size() != 0));
    checkOutput("in_ready", 32'(in_ready), 32'(expQ.size() < 2));
    checkOutput("ovf_cnt", 32'(ovf_cnt), 32'(modelCnt));
    if (expQ.size() != 0) begin
      checkOutput("result", 32'(out_result), 32'(expQ[0].res));
      checkOutput("carry", 32'(out_carry), 32'(expQ[0].c));
      checkOutput("borrow", 32'(out_borrow), 32'(expQ[0].b));
      checkOutput("zero", 32'(out_zero), 32'(expQ[0].z));
      checkOutput("neg", 32'(out_neg), 32'(expQ[0].n));
      checkOutput("ovf", 32'(out_ovf), 32'(expQ[0].o));
    end
  endtask

  // One cycle: check outputs, drive inputs as a real adder would, update model
  task automatic applyStimulus(input logic v, input logic [3:0] a, input logic [3:0] b,
                               input logic m, input logic ordy, input logic clr);
    logic [4:0] full;
    exp_t       e;
    logic       push;
    logic       pop;
    checkCycle();
    full      = m ? ({1'b0, a} + {1'b0, ~b} + 5'd1) : ({1'b0, a} + {1'b0, b});
    in_valid  = v;
    in_a      = a;
    in_b      = b;
    in_mode   = m;
    in_s      = full[3:0];
    in_cout   = full[4];
    out_ready = ordy;
    ovf_clr   = clr;
    e    = computeExpected(a, b, m);
    push = v && (expQ.size() < 2);
    pop  = (expQ.size() != 0) && ordy;
    if (pop) void'(expQ.pop_front());
    if (push) expQ.push_back(e);
    if (clr) modelCnt = 0;
    else if (push && e.o && modelCnt < 255) modelCnt++;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Directed scenarios followed by randomized traffic
  initial begin
    totalCount = 0;
    badCount   = 0;
    modelCnt   = 0;
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    in_a       = '0;
    in_b       = '0;
    in_mode    = 1'b0;
    in_s       = '0;
    in_cout    = 1'b0;
    out_ready  = 1'b0;
    ovf_clr    = 1'b0;

    #12;
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
    checkOutput("rst_result", 32'(out_result), 32'd0);
    checkOutput("rst_flags", 32'({out_carry, out_borrow, out_zero, out_neg, out_ovf}), 32'd0);
    checkOutput("rst_ovf_cnt", 32'(ovf_cnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    applyStimulus(1'b1, 4'b0011, 4'b0001, 1'b0, 1'b1, 1'b0);
    checkOutput("add_result", 32'(out_result), 32'h4);
    checkOutput("add_carry", 32'(out_carry), 32'd0);
    applyStimulus(1'b1, 4'b1001, 4'b1000, 1'b1, 1'b1, 1'b0);
    checkOutput("sub_result", 32'(out_result), 32'h1);
    checkOutput("sub_borrow0", 32'(out_borrow), 32'd0);
    applyStimulus(1'b1, 4'b0011, 4'b0101, 1'b1, 1'b1, 1'b0);
    checkOutput("sub_borrow1", 32'(out_borrow), 32'd1);
    checkOutput("sub_neg", 32'(out_neg), 32'd1);
    applyStimulus(1'b1, 4'b0111, 4'b0001, 1'b0, 1'b1, 1'b0);
    checkOutput("ovf_flag", 32'(out_ovf), 32'd1);
    checkOutput("ovf_cnt_one", 32'(ovf_cnt), 32'd1);
`ifdef ADDSUB_SAT_EN
    checkOutput("ovf_result", 32'(out_result), 32'h7);
`else
    checkOutput("ovf_result", 32'(out_result), 32'h8);
`endif
    applyStimulus(1'b0, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0);

    // Back-pressure: three offered entries, only two fit
    applyStimulus(1'b1, 4'd1, 4'd2, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 4'd3, 4'd4, 1'b0, 1'b0, 1'b0);
    checkOutput("full_in_ready", 32'(in_ready), 32'd0);
    applyStimulus(1'b1, 4'd5, 4'd6, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 4'd5, 4'd6, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 4'd5, 4'd6, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0);

    // Clear has priority over a same-cycle overflow push
    applyStimulus(1'b1, 4'b0111, 4'b0001, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 4'b1000, 4'b1111, 1'b0, 1'b1, 1'b1);
    checkOutput("clr_priority", 32'(ovf_cnt), 32'd0);

    // Saturation of the event counter
    for (int i = 0; i < 260; i++) applyStimulus(1'b1, 4'b0111, 4'b0001, 1'b0, 1'b1, 1'b0);
    checkOutput("ovf_saturate", 32'(ovf_cnt), 32'd255);
    applyStimulus(1'b0, 4'd0, 4'd0, 1'b0, 1'b1, 1'b1);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom % 4) != 0, 4'($urandom), 4'($urandom), 1'($urandom),
                    ($urandom % 3) != 0, ($urandom % 16) == 0);
    end
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0);

    // Asynchronous reset while full
    applyStimulus(1'b1, 4'b0111, 4'b0001, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 4'd2, 4'd3, 1'b1, 1'b0, 1'b0);
    in_valid = 1'b0;
    checkOutput("pre_rst_full", 32'(in_ready), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("arst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("arst_in_ready", 32'(in_ready), 32'd1);
    checkOutput("arst_ovf_cnt", 32'(ovf_cnt), 32'd0);
    checkOutput("arst_result", 32'(out_result), 32'd0);
    expQ.delete();
    modelCnt = 0;
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1'b1, 4'd6, 4'd6, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0);
    checkCycle();

    $display("test done: total=%0d bad=%0d", totalCount, badCount);
    $finish;
  end

endmodule
